// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction and a data requester onto one SRAM port,
// fixed one-cycle response. Define ARB_FAIR_EN to enable inst anti-starvation.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    // instruction requester
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // data requester
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // shared SRAM
    output logic        sram_en,
    output logic [3:0]  sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    logic grant_inst;
    logic grant_data;
    logic fair_force;
    logic resp_valid_d, resp_valid_q;
    logic resp_src_d, resp_src_q;

`ifdef ARB_FAIR_EN
    // Counts data grants that inst has waited through; at 4, inst wins once.
    logic [2:0] starve_cnt_d, starve_cnt_q;

    assign fair_force = inst_req && (starve_cnt_q == 3'd4);

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!inst_req || grant_inst)
            starve_cnt_d = 3'd0;
        else if (grant_data)
            starve_cnt_d = starve_cnt_q + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            starve_cnt_q <= 3'd0;
        else
            starve_cnt_q <= starve_cnt_d;
    end
`else
    assign fair_force = 1'b0;
`endif

    // Reset suppresses grants so no output can go active while reset is high.
    always_comb begin
        grant_inst = !reset && inst_req && (!data_req || fair_force);
        grant_data = !reset && data_req && !grant_inst;
    end

    always_comb begin
        inst_addr_ok = grant_inst;
        data_addr_ok = grant_data;
        sram_en      = grant_inst || grant_data;
        sram_we      = 4'b0000;
        sram_addr    = 32'd0;
        sram_wdata   = 32'd0;
        if (grant_data) begin
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
            sram_we    = data_wr ? data_wstrb : 4'b0000;
        end else if (grant_inst) begin
            sram_addr  = inst_addr;
        end
    end

    always_comb begin
        resp_valid_d = grant_inst || grant_data;
        resp_src_d   = grant_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_src_q   <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_src_q   <= resp_src_d;
        end
    end

    // A response pending when reset rises is dropped, not delayed.
    always_comb begin
        inst_data_ok = !reset && resp_valid_q && !resp_src_q;
        data_data_ok = !reset && resp_valid_q && resp_src_q;
        inst_rdata   = reset ? 32'd0 : sram_rdata;
        data_rdata   = reset ? 32'd0 : sram_rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural SRAM plus a response scoreboard.
// Honors ARB_FAIR_EN for the expected starvation grant pattern.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr, sram_wdata;
    logic [31:0] sram_rdata;

    int errs = 0;
    int checks = 0;

    typedef struct {
        bit          src;   // 1 = data
        bit          chk;   // compare read data
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem [0:255];

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] idx(input logic [31:0] a);
        return a[9:2] ^ a[23:16];
    endfunction

    // SRAM model: read-before-write, data one cycle after the access.
    always @(posedge clk) begin
        if (sram_en) begin
            sram_rdata <= mem[idx(sram_addr)];
            for (int b = 0; b < 4; b++)
                if (sram_we[b]) mem[idx(sram_addr)][b*8 +: 8] <= sram_wdata[b*8 +: 8];
        end
    end

    task automatic idle();
        inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0;
        data_wstrb = 0; data_addr = 0; data_wdata = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1;
        inst_req = 1; inst_addr = 32'h1c000000;
        data_req = 1; data_wr = 1; data_wstrb = 4'hf; data_addr = 32'h1c000010; data_wdata = 32'h12345678;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en} !== 5'b0 ||
            sram_we !== 4'h0 || sram_addr !== 32'd0 || sram_wdata !== 32'd0 ||
            inst_rdata !== 32'd0 || data_rdata !== 32'd0) begin
            errs++;
            $display("FAIL reset_outputs: oks=%b en=%b we=%h addr=%h wdata=%h ird=%h drd=%h, required all zero",
                     {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, sram_en, sram_we,
                     sram_addr, sram_wdata, inst_rdata, data_rdata);
        end
        next_cycle();
        reset = 0; idle();
        @(negedge clk);
        checks++;
        if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en} !== 5'b0) begin
            errs++;
            $display("FAIL post_reset_idle: oks/en=%b, required 00000",
                     {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en});
        end
    endtask

    task automatic test_inst_read();
        exp_t e;
        next_cycle();
        idle(); inst_req = 1; inst_addr = 32'h1c000000;
        @(negedge clk);
        checks++;
        if (inst_addr_ok !== 1 || data_addr_ok !== 0 || sram_en !== 1 || sram_we !== 4'h0 ||
            sram_addr !== 32'h1c000000 || sram_wdata !== 32'd0) begin
            errs++;
            $display("FAIL inst_grant: iok=%b dok=%b en=%b we=%h addr=%h wd=%h, required 1 0 1 0 1c000000 0",
                     inst_addr_ok, data_addr_ok, sram_en, sram_we, sram_addr, sram_wdata);
        end
        sb.push_back('{1'b0, 1'b1, 32'h02800421});
        next_cycle();
        idle();
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (inst_data_ok !== 1 || data_data_ok !== 0 || inst_rdata !== e.data) begin
            errs++;
            $display("FAIL inst_resp: idok=%b ddok=%b rdata=%h, required 1 0 %h",
                     inst_data_ok, data_data_ok, inst_rdata, e.data);
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        next_cycle();
        idle();
        inst_req = 1; inst_addr = 32'h1c000000;
        data_req = 1; data_wr = 1; data_wstrb = 4'hf; data_addr = 32'h1c010000; data_wdata = 32'hdeadbeef;
        @(negedge clk);
        checks++;
        if (data_addr_ok !== 1 || inst_addr_ok !== 0 || sram_we !== 4'hf ||
            sram_addr !== 32'h1c010000 || sram_wdata !== 32'hdeadbeef) begin
            errs++;
            $display("FAIL simul_c0: dok=%b iok=%b we=%h addr=%h wd=%h, required 1 0 f 1c010000 deadbeef",
                     data_addr_ok, inst_addr_ok, sram_we, sram_addr, sram_wdata);
        end
        sb.push_back('{1'b1, 1'b0, 32'd0});
        next_cycle();
        data_req = 0; data_wr = 0;
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (data_data_ok !== e.src || inst_data_ok !== 0 || inst_addr_ok !== 1 || data_addr_ok !== 0) begin
            errs++;
            $display("FAIL simul_c1: ddok=%b idok=%b iok=%b dok=%b, required 1 0 1 0",
                     data_data_ok, inst_data_ok, inst_addr_ok, data_addr_ok);
        end
        sb.push_back('{1'b0, 1'b1, mem[idx(inst_addr)]});
        next_cycle();
        idle();
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (inst_data_ok !== 1 || data_data_ok !== 0 || inst_rdata !== e.data || inst_addr_ok !== 0) begin
            errs++;
            $display("FAIL simul_c2: idok=%b ddok=%b rdata=%h iok=%b, required 1 0 %h 0",
                     inst_data_ok, data_data_ok, inst_rdata, inst_addr_ok, e.data);
        end
    endtask

    task automatic test_data_read();
        exp_t e;
        next_cycle();
        idle();
        data_req = 1; data_wr = 0; data_wstrb = 4'h3; data_addr = 32'h1c010000; data_wdata = 32'h55aa55aa;
        @(negedge clk);
        checks++;
        if (data_addr_ok !== 1 || sram_en !== 1 || sram_we !== 4'h0 || sram_addr !== 32'h1c010000) begin
            errs++;
            $display("FAIL dread_grant: dok=%b en=%b we=%h addr=%h, required 1 1 0 1c010000",
                     data_addr_ok, sram_en, sram_we, sram_addr);
        end
        // the earlier full-word write must be what comes back
        sb.push_back('{1'b1, 1'b1, 32'hdeadbeef});
        next_cycle();
        idle();
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (data_data_ok !== 1 || inst_data_ok !== 0 || data_rdata !== e.data) begin
            errs++;
            $display("FAIL dread_resp: ddok=%b idok=%b rdata=%h, required 1 0 %h",
                     data_data_ok, inst_data_ok, data_rdata, e.data);
        end
    endtask

    task automatic test_starvation();
        exp_t e;
        logic [5:0] pat;
        logic [1:0] exp_ok;
`ifdef ARB_FAIR_EN
        pat = 6'b101111;
`else
        pat = 6'b111111;
`endif
        for (int c = 0; c <= 6; c++) begin
            next_cycle();
            idle();
            if (c < 6) begin
                inst_req = 1; inst_addr = 32'h1c000000 + 32'(4 * c);
                data_req = 1; data_addr = 32'h1c000040 + 32'(4 * c);
            end
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                exp_ok = e.src ? 2'b01 : 2'b10;
            end else begin
                e = '{1'b0, 1'b0, 32'd0};
                exp_ok = 2'b00;
            end
            checks++;
            if ({inst_data_ok, data_data_ok} !== exp_ok ||
                (e.chk && (e.src ? data_rdata : inst_rdata) !== e.data)) begin
                errs++;
                $display("FAIL starve_resp c=%0d: i/d data_ok=%b ird=%h drd=%h, required %b data %h",
                         c, {inst_data_ok, data_data_ok}, inst_rdata, data_rdata, exp_ok, e.data);
            end
            if (c < 6) begin
                checks++;
                if ({inst_addr_ok, data_addr_ok} !== (pat[c] ? 2'b01 : 2'b10)) begin
                    errs++;
                    $display("FAIL starve_grant c=%0d: i/d addr_ok=%b, required %b",
                             c, {inst_addr_ok, data_addr_ok}, (pat[c] ? 2'b01 : 2'b10));
                end
                sb.push_back('{pat[c], 1'b1, mem[idx(pat[c] ? data_addr : inst_addr)]});
            end
        end
    endtask

    task automatic test_reset_midflight();
        exp_t e;
        next_cycle();
        idle();
        data_req = 1; data_wr = 0; data_addr = 32'h1c000004;
        @(negedge clk);
        checks++;
        if (data_addr_ok !== 1) begin
            errs++;
            $display("FAIL midrst_grant: dok=%b, required 1", data_addr_ok);
        end
        sb.push_back('{1'b1, 1'b1, mem[idx(data_addr)]});
        next_cycle();
        idle(); reset = 1;
        @(negedge clk);
        sb.delete();  // pending response is expected to be dropped
        checks++;
        if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en} !== 5'b0 ||
            sram_we !== 4'h0 || data_rdata !== 32'd0 || inst_rdata !== 32'd0) begin
            errs++;
            $display("FAIL midrst_c1: oks/en=%b we=%h drd=%h ird=%h, required all zero",
                     {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, sram_en},
                     sram_we, data_rdata, inst_rdata);
        end
        next_cycle();
        reset = 0;
        @(negedge clk);
        checks++;
        if (data_data_ok !== 0 || inst_data_ok !== 0) begin
            errs++;
            $display("FAIL midrst_dropped: ddok=%b idok=%b, required 0 0", data_data_ok, inst_data_ok);
        end
        next_cycle();
        inst_req = 1; inst_addr = 32'h1c000000;
        @(negedge clk);
        checks++;
        if (inst_addr_ok !== 1 || sram_addr !== 32'h1c000000) begin
            errs++;
            $display("FAIL midrst_inst_grant: iok=%b addr=%h, required 1 1c000000", inst_addr_ok, sram_addr);
        end
        sb.push_back('{1'b0, 1'b1, 32'h02800421});
        next_cycle();
        idle();
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (inst_data_ok !== 1 || inst_rdata !== e.data) begin
            errs++;
            $display("FAIL midrst_inst_resp: idok=%b rdata=%h, required 1 %h", inst_data_ok, inst_rdata, e.data);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int c = 0; c <= 8; c++) begin
            next_cycle();
            idle();
            if (c < 8) begin
                inst_req = 1; inst_addr = 32'h1c000000 + 32'(4 * c);
            end
            @(negedge clk);
            if (c > 0) begin
                e = sb.pop_front();
                checks++;
                if (inst_data_ok !== 1 || data_data_ok !== 0 || inst_rdata !== e.data) begin
                    errs++;
                    $display("FAIL stream_resp c=%0d: idok=%b ddok=%b rdata=%h, required 1 0 %h",
                             c, inst_data_ok, data_data_ok, inst_rdata, e.data);
                end
            end
            if (c < 8) begin
                checks++;
                if (inst_addr_ok !== 1 || sram_addr !== inst_addr) begin
                    errs++;
                    $display("FAIL stream_grant c=%0d: iok=%b addr=%h, required 1 %h",
                             c, inst_addr_ok, sram_addr, inst_addr);
                end
                sb.push_back('{1'b0, 1'b1, mem[idx(inst_addr)]});
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'ha5000000 + 32'(i * 32'h01010101);
        mem[idx(32'h1c000000)] = 32'h02800421;
        reset = 1;
        idle();
        test_reset();
        test_inst_read();
        test_simultaneous();
        test_data_read();
        test_starvation();
        test_reset_midflight();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 The block SHALL have the instruction requester ports:
- inst_req, input, 1: read request.
- inst_addr, input, 32: byte address.
- inst_addr_ok, output, 1: request accepted this cycle.
- inst_data_ok, output, 1: response valid this cycle.
- inst_rdata, output, 32: read data.
REQ-004 The block SHALL have the data requester ports:
- data_req, input, 1: request.
- data_wr, input, 1: 1 = write, 0 = read.
- data_wstrb, input, 4: byte write strobes.
- data_addr, input, 32: byte address.
- data_wdata, input, 32: write data.
- data_addr_ok, output, 1: request accepted this cycle.
- data_data_ok, output, 1: response valid this cycle.
- data_rdata, output, 32: read data.
REQ-005 The block SHALL have the shared SRAM ports:
- sram_en, output, 1: access enable.
- sram_we, output, 4: byte write enables.
- sram_addr, output, 32: address.
- sram_wdata, output, 32: write data.
- sram_rdata, input, 32: read data, valid one cycle after the access.

Function
REQ-006 The block SHALL grant at most one requester per cycle; grant is combinational from the current inputs and state.
REQ-007 Default priority SHALL be data over inst: data_req=1 grants data, otherwise inst_req=1 grants inst.
REQ-008 On a data grant the block SHALL drive:
- data_addr_ok=1, sram_en=1.
- sram_addr=data_addr, sram_wdata=data_wdata.
- sram_we = data_wstrb when data_wr=1, else 4'b0000.
REQ-009 On an inst grant the block SHALL drive inst_addr_ok=1, sram_en=1, sram_addr=inst_addr, sram_we=4'b0000, sram_wdata=0.
REQ-010 With no grant, sram_en, sram_we and both addr_ok outputs SHALL be 0, and sram_addr/sram_wdata SHALL be 0.
REQ-011 The block SHALL register each grant as a response record:
- resp_valid (1 bit) and resp_src (0 = inst, 1 = data).
- The record is written every cycle: resp_valid = any grant.
REQ-012 Exactly one cycle after a grant, the block SHALL assert the matching data_ok for one cycle.
- Reads and writes both receive data_ok.
- Fixed latency: 1 cycle from addr_ok to data_ok.
REQ-013 inst_rdata and data_rdata SHALL both equal sram_rdata combinationally; the value is meaningful only when the matching data_ok=1.
REQ-014 Back-to-back grants SHALL be supported: a new grant may occur in the same cycle as the data_ok of the previous grant, with no bubble.
REQ-015 Both addr_ok outputs SHALL never be 1 in the same cycle, and both data_ok outputs SHALL never be 1 in the same cycle.
REQ-016 A requester SHALL hold req and its payload stable until addr_ok; the block SHALL not store requests that are not granted.

Reset
REQ-017 While reset=1, every output SHALL be 0: addr_ok, data_ok, sram_en and sram_we are forced low regardless of inputs.
REQ-018 On reset, resp_valid, resp_src and the starvation counter SHALL clear to 0.
REQ-019 If reset is asserted in the cycle after a grant, the pending data_ok SHALL be dropped and never issued.

Configuration
REQ-020 The macro ARB_FAIR_EN SHALL select the anti-starvation feature.
REQ-021 When ARB_FAIR_EN is defined, a 3-bit counter SHALL behave as follows:
- It increments on each data grant made while inst_req=1.
- It clears on any inst grant, or in any cycle with inst_req=0.
- When the counter equals 4 and inst_req=1, inst SHALL be granted even if data_req=1; the counter then clears.
REQ-022 When ARB_FAIR_EN is undefined, no counter SHALL exist and priority SHALL be strictly data over inst (REQ-007).

Verification
REQ-023 Single inst read: inst_req=1, inst_addr=0x1c000000, sram returns 0x02800421 next cycle -> inst_addr_ok=1 in cycle 0; inst_data_ok=1 with inst_rdata=0x02800421 in cycle 1.
REQ-024 Simultaneous request: inst_req=1, data_req=1, data_wr=1, wstrb=4'hF, addr=0x1c010000, wdata=0xdeadbeef -> cycle 0 sram_we=4'hF to 0x1c010000 and data_addr_ok=1; cycle 1 data_data_ok=1 and inst_addr_ok=1; cycle 2 inst_data_ok=1.
REQ-025 Data read with strobes ignored: data_wr=0, wstrb=4'h3 -> sram_we=4'b0000, data_data_ok after 1 cycle.
REQ-026 Starvation:
- Stimulus: data_req and inst_req held high for 6 cycles.
- With ARB_FAIR_EN: grants are D,D,D,D,I,D.
- Without ARB_FAIR_EN: grants are D×6.
REQ-027 Reset mid-flight: data read granted in cycle 0, reset=1 in cycle 1 -> data_data_ok=0 in cycle 1 and all outputs 0; after reset deasserts, the first grant behaves per REQ-023.
REQ-028 Continuous inst streaming: inst_req=1 for 8 cycles with addresses incrementing by 4 -> inst_addr_ok=1 in every cycle and inst_data_ok=1 in cycles 1-8 with matching data.
